// File: rtl/clock_activity_monitor.sv
// clock_activity_monitor
// Decides, in the reference clock domain, whether an asynchronous clock is
// alive and toggling within an acceptable edge-rate band. The monitored clock
// is synchronized as data. Its rising edges are counted over fixed windows of
// the reference clock, and hysteresis is applied before the clock is declared
// running or lost.
//
// Ports:
//   clock              in   reference clock; all logic on its rising edge
//   reset              in   asynchronous active-high reset
//   monitored_clock    in   clock under observation (async data, < clock/2)
//   clock_running      out  1 only while the monitored clock is RUNNING
//   clock_not_running  out  complement of clock_running, drives clock-select
//   clock_lost         out  one-cycle pulse on RUNNING -> LOST
//   window_edge_count  out  edge count of the last completed window
module clock_activity_monitor #(
    parameter int unsigned STAGES        = 2,
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned MIN_EDGES     = 1,
    parameter int unsigned MAX_EDGES     = 128,
    parameter int unsigned VALID_WINDOWS = 2,
    localparam int unsigned COUNT_WIDTH  = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   monitored_clock,
    output logic                   clock_running,
    output logic                   clock_not_running,
    output logic                   clock_lost,
    output logic [COUNT_WIDTH-1:0] window_edge_count
);

    localparam int unsigned GOOD_WIDTH  = $clog2(VALID_WINDOWS + 1);
    localparam int unsigned FINAL_WIDTH = COUNT_WIDTH + 1;

    typedef enum logic [1:0] {
        CHECKING = 2'd0,
        RUNNING  = 2'd1,
        LOST     = 2'd2
    } state_e;

    logic [STAGES-1:0]      sync_q;
    logic                   hist_q;
    logic [COUNT_WIDTH-1:0] win_q, win_d;
    logic [COUNT_WIDTH-1:0] edge_q, edge_d;
    logic [GOOD_WIDTH-1:0]  good_q, good_d, good_inc;
    state_e                 state_q, state_d;
    logic                   running_q, running_d;
    logic                   not_running_q, not_running_d;
    logic                   lost_q, lost_d;
    logic [COUNT_WIDTH-1:0] wec_q, wec_d;

    logic                   edge_pulse;
    logic                   win_end;
    logic [FINAL_WIDTH-1:0] final_sum;
    logic [COUNT_WIDTH-1:0] final_count;
    logic                   good_window;

    // Synchronizer chain plus one history flop for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], monitored_clock};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign edge_pulse = sync_q[STAGES-1] & ~hist_q;
    assign win_end    = (win_q == COUNT_WIDTH'(WINDOW_CYCLES - 1));

    // An edge in the window-end cycle belongs to the window being closed
    assign final_sum   = FINAL_WIDTH'(edge_q) + FINAL_WIDTH'(edge_pulse);
    assign final_count = (final_sum > FINAL_WIDTH'(WINDOW_CYCLES)) ?
                         COUNT_WIDTH'(WINDOW_CYCLES) : final_sum[COUNT_WIDTH-1:0];
    assign good_window = (final_count >= COUNT_WIDTH'(MIN_EDGES)) &&
                         (final_count <= COUNT_WIDTH'(MAX_EDGES));

    assign good_inc = (good_q == GOOD_WIDTH'(VALID_WINDOWS)) ?
                      good_q : good_q + GOOD_WIDTH'(1);

    // Window and edge counters; edge counter restarts empty each window
    always_comb begin
        win_d  = win_end ? '0 : win_q + COUNT_WIDTH'(1);
        edge_d = edge_q;
        if (win_end) begin
            edge_d = '0;
        end else if (edge_pulse && (edge_q != COUNT_WIDTH'(WINDOW_CYCLES))) begin
            edge_d = edge_q + COUNT_WIDTH'(1);
        end
    end

    // Next-state and registered-output logic; decisions only at window end
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        lost_d  = 1'b0;
        wec_d   = wec_q;
        if (win_end) begin
            wec_d = final_count;
            case (state_q)
                RUNNING: begin
                    if (!good_window) begin
                        state_d = LOST;
                        lost_d  = 1'b1;
                        good_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                CHECKING, LOST: begin
                    if (good_window) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_WIDTH'(VALID_WINDOWS)) begin
                            state_d = RUNNING;
                        end
                    end else begin
                        good_d  = '0;
                        state_d = LOST;
                    end
                end
                default: begin
                    state_d = LOST;
                    good_d  = '0;
                end
            endcase
        end
        running_d     = (state_d == RUNNING);
        not_running_d = (state_d != RUNNING);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_q         <= '0;
            edge_q        <= '0;
            good_q        <= '0;
            state_q       <= CHECKING;
            running_q     <= 1'b0;
            not_running_q <= 1'b1;
            lost_q        <= 1'b0;
            wec_q         <= '0;
        end else begin
            win_q         <= win_d;
            edge_q        <= edge_d;
            good_q        <= good_d;
            state_q       <= state_d;
            running_q     <= running_d;
            not_running_q <= not_running_d;
            lost_q        <= lost_d;
            wec_q         <= wec_d;
        end
    end

    assign clock_running     = running_q;
    assign clock_not_running = not_running_q;
    assign clock_lost        = lost_q;
    assign window_edge_count = wec_q;

endmodule

// File: tb/tb_clock_activity_monitor.sv
// Directed bench for clock_activity_monitor with 16-cycle windows, 2..6 good
// edges and 2 valid windows. The monitored clock is generated from a cycle
// index: cyc counts reference posedges since reset release, and the value
// applied just after posedge n is mval(n).
module tb_clock_activity_monitor;

    localparam int unsigned CW = $clog2(16 + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          monitored_clock = 1'b0;
    logic          clock_running;
    logic          clock_not_running;
    logic          clock_lost;
    logic [CW-1:0] window_edge_count;

    int        n_checks = 0;
    int        n_pass   = 0;
    int        cyc      = 0;
    int        mode     = 0;   // 0 idle, 1 periodic from start, 2 per-window mask
    int        start    = 0;
    int        period   = 8;
    logic [7:0] mask    = '0;

    clock_activity_monitor #(
        .STAGES       (2),
        .WINDOW_CYCLES(16),
        .MIN_EDGES    (2),
        .MAX_EDGES    (6),
        .VALID_WINDOWS(2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .monitored_clock  (monitored_clock),
        .clock_running    (clock_running),
        .clock_not_running(clock_not_running),
        .clock_lost       (clock_lost),
        .window_edge_count(window_edge_count)
    );

    always #5 clock = ~clock;

    function automatic logic mval(input int n);
        logic r;
        r = 1'b0;
        if (mode == 1) begin
            r = (n >= start) && (((n - start) % period) < (period / 2));
        end else if (mode == 2) begin
            if ((n / 16) < 8) r = mask[n / 16] && ((n % 8) < 4);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        monitored_clock = mval(cyc);
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        mode  = 0;
        monitored_clock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic release_reset(input int nmode, input int nstart, input int nperiod,
                                 input logic [7:0] nmask);
        mode   = nmode;
        start  = nstart;
        period = nperiod;
        mask   = nmask;
        cyc    = 0;
        reset  = 1'b0;
        monitored_clock = mval(0);
    endtask

    initial begin
        // 1 + 5: idle clock goes LOST silently, then good/bad/good/good flapping
        @(posedge clock);
        #1;
        enter_reset();
        check("rst_not_running", 32'(clock_not_running), 1);
        check("rst_running", 32'(clock_running), 0);
        check("rst_lost", 32'(clock_lost), 0);
        check("rst_wec", 32'(window_edge_count), 0);
        release_reset(2, 0, 8, 8'b0001_1010);
        tick_to(16);
        check("idle_w1_wec", 32'(window_edge_count), 0);
        check("idle_w1_lost", 32'(clock_lost), 0);
        check("idle_w1_running", 32'(clock_running), 0);
        tick_to(32);
        check("flap_w2_wec", 32'(window_edge_count), 2);
        check("flap_w2_running", 32'(clock_running), 0);
        tick_to(48);
        check("flap_w3_wec", 32'(window_edge_count), 0);
        check("flap_w3_running", 32'(clock_running), 0);
        check("flap_w3_lost", 32'(clock_lost), 0);
        tick_to(64);
        check("flap_w4_wec", 32'(window_edge_count), 2);
        check("flap_w4_running", 32'(clock_running), 0);
        tick_to(80);
        check("flap_w5_wec", 32'(window_edge_count), 2);
        check("flap_w5_running", 32'(clock_running), 1);
        check("flap_w5_not_running", 32'(clock_not_running), 0);

        // 2 + 3: period 8 reaches RUNNING at 32, stops, is lost, restarts
        enter_reset();
        release_reset(1, 0, 8, '0);
        tick_to(16);
        check("p8_w1_wec", 32'(window_edge_count), 2);
        check("p8_w1_running", 32'(clock_running), 0);
        tick_to(31);
        check("p8_c31_running", 32'(clock_running), 0);
        tick_to(32);
        check("p8_w2_wec", 32'(window_edge_count), 2);
        check("p8_w2_running", 32'(clock_running), 1);
        tick_to(36);
        mode = 0;
        tick_to(47);
        check("stop_c47_running", 32'(clock_running), 1);
        check("stop_c47_lost", 32'(clock_lost), 0);
        tick_to(48);
        check("stop_w3_wec", 32'(window_edge_count), 1);
        check("stop_w3_running", 32'(clock_running), 0);
        check("stop_w3_not_running", 32'(clock_not_running), 1);
        check("stop_w3_lost", 32'(clock_lost), 1);
        tick_to(49);
        check("stop_c49_lost", 32'(clock_lost), 0);
        tick_to(63);
        mode  = 1;
        start = 64;
        tick_to(64);
        check("stop_w4_wec", 32'(window_edge_count), 0);
        check("stop_w4_lost", 32'(clock_lost), 0);
        tick_to(80);
        check("restart_w5_wec", 32'(window_edge_count), 2);
        check("restart_w5_running", 32'(clock_running), 0);
        tick_to(95);
        check("restart_c95_running", 32'(clock_running), 0);
        tick_to(96);
        check("restart_w6_running", 32'(clock_running), 1);

        // 4: period 2 is too fast; every window is bad
        enter_reset();
        release_reset(1, 0, 2, '0);
        tick_to(16);
        check("p2_w1_wec", 32'(window_edge_count), 7);
        tick_to(32);
        check("p2_w2_wec", 32'(window_edge_count), 8);
        check("p2_w2_running", 32'(clock_running), 0);
        tick_to(48);
        check("p2_w3_wec", 32'(window_edge_count), 8);
        check("p2_w3_running", 32'(clock_running), 0);
        check("p2_w3_lost", 32'(clock_lost), 0);

        // 6: async reset while RUNNING, then edges aligned to window end
        enter_reset();
        release_reset(1, 0, 8, '0);
        tick_to(32);
        check("mid_pre_running", 32'(clock_running), 1);
        tick_to(40);
        reset = 1'b1;
        #1;
        check("mid_async_running", 32'(clock_running), 0);
        check("mid_async_not_running", 32'(clock_not_running), 1);
        check("mid_async_wec", 32'(window_edge_count), 0);
        check("mid_async_lost", 32'(clock_lost), 0);
        mode = 0;
        monitored_clock = 1'b0;
        repeat (3) tick();
        release_reset(1, 5, 8, '0);
        tick_to(16);
        check("align_w1_wec", 32'(window_edge_count), 2);
        check("align_w1_running", 32'(clock_running), 0);
        tick_to(31);
        check("align_c31_running", 32'(clock_running), 0);
        tick_to(32);
        check("align_w2_wec", 32'(window_edge_count), 2);
        check("align_w2_running", 32'(clock_running), 1);
        tick_to(48);
        check("align_w3_wec", 32'(window_edge_count), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
